// File: rtl/key_ctrl_pkg.sv
// Shared constants for the key controller and the LED pattern block that consumes ctrl.
package key_ctrl_pkg;

  localparam int CTRL_W = 2;

  localparam logic [CTRL_W-1:0] MODE_FLOW     = 2'd0;
  localparam logic [CTRL_W-1:0] MODE_BLINK    = 2'd1;
  localparam logic [CTRL_W-1:0] MODE_FLOW_INV = 2'd2;
  localparam logic [CTRL_W-1:0] MODE_LAST     = 2'd2;

  function automatic int db_cycles(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms;
  endfunction

  // UP walks 0->1->2->0, DOWN walks 0->2->1->0; an illegal value recovers to MODE_FLOW.
  function automatic logic [CTRL_W-1:0] mode_step(input logic [CTRL_W-1:0] cur, input logic up);
    logic [CTRL_W-1:0] nxt;
    if (up) begin
      case (cur)
        MODE_FLOW:     nxt = MODE_BLINK;
        MODE_BLINK:    nxt = MODE_FLOW_INV;
        MODE_FLOW_INV: nxt = MODE_FLOW;
        default:       nxt = MODE_FLOW;
      endcase
    end else begin
      case (cur)
        MODE_FLOW:     nxt = MODE_LAST;
        MODE_FLOW_INV: nxt = MODE_BLINK;
        MODE_BLINK:    nxt = MODE_FLOW;
        default:       nxt = MODE_FLOW;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter and press pulse.
// Defining KEY_CTRL_REPEAT_EN adds a hold counter for auto-repeat presses.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic state,
  output logic press
);

  localparam int DB_CNT = db_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int CNT_W  = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             state_r;
  logic             press_r;
  logic             diff_s;
  logic             upd_s;
  logic             press_set_s;

  // The raw key is active-low; state_r holds the debounced level with 1 = pressed.
  always_comb begin
    diff_s = (~sync2_r) != state_r;
    upd_s  = diff_s && (cnt_r == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      state_r <= 1'b0;
    end else if (!diff_s) begin
      cnt_r   <= '0;
    end else if (upd_s) begin
      cnt_r   <= '0;
      state_r <= ~state_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

`ifdef KEY_CTRL_REPEAT_EN
  localparam int HOLD_W = $clog2(CLK_FREQ);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(CLK_FREQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(CLK_FREQ / 2);

  logic [HOLD_W-1:0] hold_r;
  logic              rep_s;

  always_comb begin
    rep_s       = state_r && !upd_s && (hold_r == HOLD_LAST);
    press_set_s = (upd_s && !state_r) || rep_s;
  end

  // Reloading to half the period makes later repeats arrive every CLK_FREQ/2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
    end else if (!state_r || upd_s) begin
      hold_r <= '0;
    end else if (rep_s) begin
      hold_r <= HOLD_RELOAD;
    end else begin
      hold_r <= hold_r + HOLD_W'(1);
    end
  end
`else
  always_comb begin
    press_set_s = upd_s && !state_r;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_r <= 1'b0;
    end else begin
      press_r <= press_set_s;
    end
  end

  assign state = state_r;
  assign press = press_r;

endmodule

// File: rtl/key_ctrl.sv
// Two debounced push-buttons (UP = key[0], DOWN = key[1]) stepping the LED mode on ctrl.
// Optional auto-repeat while a key is held is enabled by defining KEY_CTRL_REPEAT_EN.
module key_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key,
  output logic [1:0]        key_state,
  output logic [1:0]        key_press,
  output logic [CTRL_W-1:0] ctrl
);

  logic [CTRL_W-1:0] ctrl_r;
  logic              up_s;
  logic              down_s;

  key_debounce #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_up (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key[0]),
    .state   (key_state[0]),
    .press   (key_press[0])
  );

  key_debounce #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_down (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key[1]),
    .state   (key_state[1]),
    .press   (key_press[1])
  );

  // Simultaneous presses cancel out and leave the mode alone.
  always_comb begin
    up_s   = key_press[0] & ~key_press[1];
    down_s = key_press[1] & ~key_press[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= MODE_FLOW;
    end else if (up_s) begin
      ctrl_r <= mode_step(ctrl_r, 1'b1);
    end else if (down_s) begin
      ctrl_r <= mode_step(ctrl_r, 1'b0);
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  assign ctrl = ctrl_r;

endmodule
